pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter NUM_STAGES, default 5, pipeline stage count; latch count L = NUM_STAGES-1; legal range 3..8.
REQ-002 Parameter REG_ADDR_W, default 5, register address width.
REQ-003 Parameter CNT_W, default 32, performance counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_run_cont  input  1  level; request continuous execution.
REQ-007 i_step  input  1  one-cycle pulse; request single-cycle advance.
REQ-008 i_halt_instr  input  1  halt instruction present in ID.
REQ-009 i_id_rs / i_id_rt  input  REG_ADDR_W each  source registers of the ID instruction.
REQ-010 i_id_uses_rt  input  1  ID instruction reads rt.
REQ-011 i_ex_mem_read / i_ex_rt  input  1 / REG_ADDR_W  EX instruction is a load, and its destination.
REQ-012 i_branch_taken  input  1  branch resolved taken in MEM.
REQ-013 o_pc_en  output  1  PC update enable.
REQ-014 o_latch_en  output  L  per-latch enable; bit 0 = IF/ID.
REQ-015 o_latch_flush  output  L  per-latch synchronous clear (bubble insert).
REQ-016 o_valid  output  NUM_STAGES  per-stage occupancy; bit 0 = IF.
REQ-017 o_state  output  3  FSM state encoding.
REQ-018 o_halted  output  1  high in HALTED.
REQ-019 o_cycle_cnt / o_stall_cnt  output  CNT_W each  performance counters.

Function
REQ-020 FSM states: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4; registered.
REQ-021 IDLE: all enables 0; i_run_cont -> RUN; else i_step -> STEP; i_run_cont has priority.
REQ-022 RUN: advance every cycle; i_run_cont low -> IDLE; i_halt_instr (advance cycle) -> DRAIN.
REQ-023 STEP: exactly one advance cycle, then IDLE; i_halt_instr during STEP -> DRAIN.
REQ-024 Advance cycle: o_pc_en=1, o_latch_en all 1, o_latch_flush all 0, unless REQ-025/026 apply; all enable/flush outputs combinational from state and inputs.
REQ-025 Load-use hazard: i_ex_mem_read & i_ex_rt!=0 & (i_ex_rt==i_id_rs | (i_id_uses_rt & i_ex_rt==i_id_rt)) -> o_pc_en=0, o_latch_en[0]=0, o_latch_flush[1]=1; others advance.
REQ-026 i_branch_taken on advance cycle -> o_latch_flush[2:0]=3'b111, o_pc_en=1; overrides load-use.
REQ-027 DRAIN: o_pc_en=0, o_latch_flush[0]=1, others advance each cycle regardless of i_run_cont; exit to HALTED when o_valid[NUM_STAGES-1:1] all 0.
REQ-028 HALTED: all enables 0, o_halted=1; exit only via rst.
REQ-029 o_valid: on advance, shift left by one with bit0 = o_pc_en; flushed latch clears the corresponding downstream valid bit; non-advance cycles hold.
REQ-030 o_cycle_cnt increments every advance cycle; o_stall_cnt increments on load-use stall cycles; both saturate at all-ones, no wrap.
REQ-031 Simultaneous i_step and i_halt_instr in IDLE: STEP taken; halt honoured on that STEP cycle.

Reset
REQ-032 rst -> state IDLE, o_valid=0, counters 0, o_halted=0, all enables/flushes 0, same edge, including mid-DRAIN or HALTED.
REQ-033 rst overrides all other inputs in the same cycle.

Configuration
REQ-034 Macro PIPELINE_CONTROLLER_PERF_CNT_EN defined: counters per REQ-030.
REQ-035 Macro undefined: no counter registers; o_cycle_cnt and o_stall_cnt tied 0; all other behaviour identical.

Verification
REQ-036 rst, i_run_cont=1 for 10 cycles, no hazards -> o_cycle_cnt=10, o_valid=5'b11111 after 5 cycles.
REQ-037 RUN, i_ex_mem_read=1, i_ex_rt=8, i_id_rs=8 for one cycle -> o_pc_en=0, o_latch_en[0]=0, o_latch_flush[1]=1, o_stall_cnt=1; same with i_ex_rt=0 -> no stall.
REQ-038 RUN, i_branch_taken=1 with load-use active -> o_latch_flush=4'b0111, o_pc_en=1, o_stall_cnt unchanged.
REQ-039 IDLE, three i_step pulses 4 cycles apart -> exactly 3 advance cycles, o_cycle_cnt=3, o_state back to 0 between.
REQ-040 RUN full pipe, i_halt_instr=1 -> DRAIN for 4 cycles, then o_halted=1, o_valid=0; i_run_cont held 1 has no effect; rst -> IDLE.
REQ-041 Macro undefined, REQ-036 stimulus -> counters read 0, all other responses unchanged.

Source files
------------

// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the pipeline datapath and its controller.
// master drives the datapath status, slave (the controller) drives enables/flushes/status.
interface pipeline_controller_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                    i_run_cont;
  logic                    i_step;
  logic                    i_halt_instr;
  logic [REG_ADDR_W-1:0]   i_id_rs;
  logic [REG_ADDR_W-1:0]   i_id_rt;
  logic                    i_id_uses_rt;
  logic                    i_ex_mem_read;
  logic [REG_ADDR_W-1:0]   i_ex_rt;
  logic                    i_branch_taken;

  logic                    o_pc_en;
  logic [NUM_STAGES-2:0]   o_latch_en;
  logic [NUM_STAGES-2:0]   o_latch_flush;
  logic [NUM_STAGES-1:0]   o_valid;
  logic [2:0]              o_state;
  logic                    o_halted;
  logic [CNT_W-1:0]        o_cycle_cnt;
  logic [CNT_W-1:0]        o_stall_cnt;

  modport master (
    output i_run_cont, i_step, i_halt_instr, i_id_rs, i_id_rt, i_id_uses_rt,
           i_ex_mem_read, i_ex_rt, i_branch_taken,
    input  o_pc_en, o_latch_en, o_latch_flush, o_valid, o_state, o_halted,
           o_cycle_cnt, o_stall_cnt
  );

  modport slave (
    input  i_run_cont, i_step, i_halt_instr, i_id_rs, i_id_rt, i_id_uses_rt,
           i_ex_mem_read, i_ex_rt, i_branch_taken,
    output o_pc_en, o_latch_en, o_latch_flush, o_valid, o_state, o_halted,
           o_cycle_cnt, o_stall_cnt
  );
endinterface

// File: rtl/pipeline_controller.sv
// Run/step/drain/halt sequencer for an in-order pipeline with load-use stall and branch flush.
// Define PIPELINE_CONTROLLER_PERF_CNT_EN to build the saturating cycle/stall counters.
module pipeline_controller #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_controller_if.slave  bus
);

  localparam int L = NUM_STAGES - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic                  pc_en;
  logic [L-1:0]          latch_en;
  logic [L-1:0]          latch_flush;
  logic                  advance;
  logic                  drain;
  logic                  load_use;
  logic [REG_ADDR_W-1:0] ex_rt;

  assign ex_rt    = bus.i_ex_rt;
  assign load_use = bus.i_ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == bus.i_id_rs) || (bus.i_id_uses_rt && (ex_rt == bus.i_id_rt)));

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    latch_en    = '0;
    latch_flush = '0;
    advance     = 1'b0;
    drain       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_run_cont)  state_d = RUN;
        else if (bus.i_step) state_d = STEP;
      end
      RUN, STEP: begin
        advance  = 1'b1;
        pc_en    = 1'b1;
        latch_en = '1;
        // A taken branch squashes the wrong-path instructions and makes any load-use stall moot.
        if (bus.i_branch_taken) begin
          for (int i = 0; i < L; i++) begin
            if (i < 3) latch_flush[i] = 1'b1;
          end
        end else if (load_use) begin
          pc_en          = 1'b0;
          latch_en[0]    = 1'b0;
          latch_flush[1] = 1'b1;
        end
        if (bus.i_halt_instr)                         state_d = DRAIN;
        else if ((state_q == STEP) || !bus.i_run_cont) state_d = IDLE;
      end
      DRAIN: begin
        drain          = 1'b1;
        latch_en       = '1;
        latch_flush[0] = 1'b1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase

    valid_d = valid_q;
    if (advance || drain) begin
      // A stalled IF keeps its instruction; otherwise IF fills exactly when the PC moves.
      valid_d[0] = pc_en | (~latch_en[0] & valid_q[0]);
      for (int s = 1; s < NUM_STAGES; s++) begin
        if (latch_flush[s-1])   valid_d[s] = 1'b0;
        else if (latch_en[s-1]) valid_d[s] = valid_q[s-1];
      end
    end
    // Leave DRAIN on the edge that empties the last occupied stage.
    if (drain && (valid_d[NUM_STAGES-1:1] == '0)) state_d = HALTED;

    if (rst) begin
      pc_en       = 1'b0;
      latch_en    = '0;
      latch_flush = '0;
      advance     = 1'b0;
      drain       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

`ifdef PIPELINE_CONTROLLER_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_cyc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Branch forces pc_en high, so a held PC on an advance cycle is exactly a load-use stall.
  assign stall_cyc = advance & ~pc_en;

  always_comb begin
    cycle_cnt_d = advance   ? sat_inc(cycle_cnt_q) : cycle_cnt_q;
    stall_cnt_d = stall_cyc ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_cycle_cnt = cycle_cnt_q;
  assign bus.o_stall_cnt = stall_cnt_q;
`else
  assign bus.o_cycle_cnt = {CNT_W{1'b0}};
  assign bus.o_stall_cnt = {CNT_W{1'b0}};
`endif

  assign bus.o_pc_en       = pc_en;
  assign bus.o_latch_en    = latch_en;
  assign bus.o_latch_flush = latch_flush;
  assign bus.o_valid       = valid_q;
  assign bus.o_state       = state_q;
  assign bus.o_halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized and directed bench for pipeline_controller against a per-cycle behavioural model.
module tb_pipeline_controller;
  localparam int NS   = 5;
  localparam int RAW  = 5;
  localparam int CW   = 4;
  localparam int L    = NS - 1;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PIPELINE_CONTROLLER_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_controller_if #(.NUM_STAGES(NS), .REG_ADDR_W(RAW), .CNT_W(CW)) bus ();

  pipeline_controller #(.NUM_STAGES(NS), .REG_ADDR_W(RAW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: mode uses the documented state numbers, occupancy one flag per stage
  int m_mode;
  bit m_occ[NS];
  int m_cyc;
  int m_stl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] occ_vec();
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = m_occ[s];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    for (int s = 0; s < NS; s++) m_occ[s] = 1'b0;
    m_cyc = 0;
    m_stl = 0;
  endtask

  task automatic clr_in();
    bus.i_run_cont     = 1'b0;
    bus.i_step         = 1'b0;
    bus.i_halt_instr   = 1'b0;
    bus.i_id_rs        = '0;
    bus.i_id_rt        = '0;
    bus.i_id_uses_rt   = 1'b0;
    bus.i_ex_mem_read  = 1'b0;
    bus.i_ex_rt        = '0;
    bus.i_branch_taken = 1'b0;
  endtask

  // One clock: check every output against the model, then advance the model across the edge.
  task automatic tick();
    bit adv, drn, lu, stl, br, any;
    logic e_pc;
    logic [L-1:0] e_len, e_fl;
    bit nocc[NS];
    int nmode;
    #1;
    adv = !rst && (m_mode == 1 || m_mode == 2);
    drn = !rst && (m_mode == 3);
    br  = bus.i_branch_taken;
    lu  = bus.i_ex_mem_read && (bus.i_ex_rt != 0) &&
          ((bus.i_ex_rt == bus.i_id_rs) || (bus.i_id_uses_rt && bus.i_ex_rt == bus.i_id_rt));
    stl = adv && lu && !br;
    e_pc  = adv && !stl;
    e_len = (adv || drn) ? '1 : '0;
    if (stl) e_len[0] = 1'b0;
    e_fl = '0;
    if (adv && br) for (int i = 0; i < 3 && i < L; i++) e_fl[i] = 1'b1;
    if (stl) e_fl[1] = 1'b1;
    if (drn) e_fl[0] = 1'b1;

    check("pc_en",       bus.o_pc_en,       e_pc);
    check("latch_en",    bus.o_latch_en,    e_len);
    check("latch_flush", bus.o_latch_flush, e_fl);
    check("valid",       bus.o_valid,       occ_vec());
    check("state",       bus.o_state,       m_mode);
    check("halted",      bus.o_halted,      m_mode == 4);
    check("cycle_cnt",   bus.o_cycle_cnt,   PERF ? m_cyc : 0);
    check("stall_cnt",   bus.o_stall_cnt,   PERF ? m_stl : 0);

    for (int s = 0; s < NS; s++) nocc[s] = m_occ[s];
    if (adv && br) begin
      nocc[0] = 1'b1;
      for (int s = 1; s < NS; s++) nocc[s] = (s <= 3) ? 1'b0 : m_occ[s-1];
    end else if (stl) begin
      nocc[2] = 1'b0;
      for (int s = 3; s < NS; s++) nocc[s] = m_occ[s-1];
    end else if (adv) begin
      nocc[0] = 1'b1;
      for (int s = 1; s < NS; s++) nocc[s] = m_occ[s-1];
    end else if (drn) begin
      nocc[0] = 1'b0;
      nocc[1] = 1'b0;
      for (int s = 2; s < NS; s++) nocc[s] = m_occ[s-1];
    end
    any = 1'b0;
    for (int s = 1; s < NS; s++) any |= nocc[s];

    case (m_mode)
      0:       nmode = bus.i_run_cont ? 1 : (bus.i_step ? 2 : 0);
      1:       nmode = bus.i_halt_instr ? 3 : (bus.i_run_cont ? 1 : 0);
      2:       nmode = bus.i_halt_instr ? 3 : 0;
      3:       nmode = any ? 3 : 4;
      default: nmode = 4;
    endcase

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_mode = nmode;
      for (int s = 0; s < NS; s++) m_occ[s] = nocc[s];
      if (adv && m_cyc < CMAX) m_cyc++;
      if (stl && m_stl < CMAX) m_stl++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    clr_in();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // continuous run, no hazards
    bus.i_run_cont = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) check("run_valid_full", bus.o_valid, 5'b11111);
    end
    bus.i_run_cont = 1'b0;
    tick();
    check("run_cycle_cnt", bus.o_cycle_cnt, PERF ? 10 : 0);
    check("run_back_idle", bus.o_state, 0);

    // load-use stall, then rt=0 which must not stall
    do_reset();
    bus.i_run_cont = 1'b1;
    repeat (7) tick();
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_rt       = 5'd8;
    bus.i_id_rs       = 5'd8;
    #1;
    check("lu_pc_en",    bus.o_pc_en, 1'b0);
    check("lu_latch_en0", bus.o_latch_en[0], 1'b0);
    check("lu_flush1",   bus.o_latch_flush[1], 1'b1);
    tick();
    check("lu_stall_cnt", bus.o_stall_cnt, PERF ? 1 : 0);
    bus.i_ex_rt = 5'd0;
    bus.i_id_rs = 5'd0;
    #1;
    check("lu_r0_pc_en", bus.o_pc_en, 1'b1);
    tick();
    check("lu_r0_stall_cnt", bus.o_stall_cnt, PERF ? 1 : 0);

    // branch overrides load-use
    bus.i_ex_rt        = 5'd8;
    bus.i_id_rs        = 5'd8;
    bus.i_branch_taken = 1'b1;
    #1;
    check("br_flush", bus.o_latch_flush, 4'b0111);
    check("br_pc_en", bus.o_pc_en, 1'b1);
    tick();
    check("br_stall_cnt", bus.o_stall_cnt, PERF ? 1 : 0);

    // single steps four cycles apart
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.i_step = 1'b1;
      tick();
      bus.i_step = 1'b0;
      tick();
      check("step_back_idle", bus.o_state, 0);
      tick();
      tick();
    end
    check("step_cycle_cnt", bus.o_cycle_cnt, PERF ? 3 : 0);

    // step and halt together in IDLE
    do_reset();
    bus.i_step       = 1'b1;
    bus.i_halt_instr = 1'b1;
    tick();
    check("stephalt_step", bus.o_state, 2);
    bus.i_step = 1'b0;
    tick();
    check("stephalt_drain", bus.o_state, 3);
    n = 0;
    while (bus.o_state == 3 && n < 20) begin
      tick();
      n++;
    end
    check("stephalt_halted", bus.o_halted, 1'b1);

    // full pipe halt: drain, halted, run_cont ignored, reset recovers
    do_reset();
    bus.i_run_cont = 1'b1;
    repeat (8) tick();
    bus.i_halt_instr = 1'b1;
    tick();
    n = 0;
    while (bus.o_state == 3 && n < 20) begin
      tick();
      n++;
    end
    check("halt_drain_cycles", n, 4);
    check("halt_halted", bus.o_halted, 1'b1);
    check("halt_valid", bus.o_valid, 0);
    repeat (3) tick();
    check("halt_sticky", bus.o_halted, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_rst_state", bus.o_state, 0);
    check("halt_rst_halted", bus.o_halted, 1'b0);

    // counter saturation
    do_reset();
    bus.i_run_cont = 1'b1;
    repeat (25) tick();
    check("sat_cycle_cnt", bus.o_cycle_cnt, PERF ? CMAX : 0);

    // random traffic
    do_reset();
    for (int it = 0; it < 2000; it++) begin
      if ($urandom_range(0, 15) == 0) bus.i_run_cont = ~bus.i_run_cont;
      bus.i_step         = ($urandom_range(0, 7) == 0);
      bus.i_halt_instr   = ($urandom_range(0, 23) == 0);
      bus.i_branch_taken = ($urandom_range(0, 5) == 0);
      bus.i_ex_mem_read  = ($urandom_range(0, 2) == 0);
      bus.i_ex_rt        = 5'($urandom_range(0, 3));
      bus.i_id_rs        = 5'($urandom_range(0, 3));
      bus.i_id_rt        = 5'($urandom_range(0, 3));
      bus.i_id_uses_rt   = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0) || (m_mode == 4 && $urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
